// File: rtl/jt1943_sec_prober.sv
// Bus master that walks a challenge/response table against the 1943 protection
// responder and reports pass/fail, mismatch count and first failing index.
module jt1943_sec_prober #(
    parameter int N    = 32,
    parameter int AW   = 5,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    input  logic          tbl_ok,
    output logic          sec_cs,
    output logic          sec_wr_n,
    output logic [7:0]    sec_dout,
    input  logic [7:0]    sec_din
);

    localparam int WW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [WW-1:0] WLAST = WW'(WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   index;
    logic            addr_settled;
    logic [7:0]      expected;
    logic [WW-1:0]   wcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            index        <= '0;
            addr_settled <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_cnt      <= '0;
            first_err    <= '0;
            tbl_addr     <= '0;
            sec_cs       <= 1'b0;
            sec_wr_n     <= 1'b1;
            sec_dout     <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        index        <= '0;
                        tbl_addr     <= '0;
                        err_cnt      <= '0;
                        first_err    <= '0;
                        pass         <= 1'b0;
                        addr_settled <= 1'b0;
                        state        <= S_FETCH;
                    end
                end
                // tbl_ok seen in the same cycle the address moved refers to the old address
                S_FETCH: begin
                    if (addr_settled && tbl_ok) begin
                        sec_dout <= tbl_data[15:8];
                        expected <= tbl_data[7:0];
                        sec_cs   <= 1'b1;
                        sec_wr_n <= 1'b0;
                        state    <= S_WRITE;
                    end else begin
                        addr_settled <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (cen) begin
                        sec_cs   <= 1'b0;
                        sec_wr_n <= 1'b1;
                        wcnt     <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cen) begin
                        if (wcnt == WLAST) begin
                            state <= S_CHECK;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (sec_din != expected) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_err <= index;
                        end
                    end
                    if (index == LAST) begin
                        state <= S_DONE;
                    end else begin
                        index        <= index + 1'b1;
                        tbl_addr     <= index + 1'b1;
                        addr_settled <= 1'b0;
                        state        <= S_FETCH;
                    end
                end
                // done rises together with the final pass flag and busy release
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_cnt == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt1943_sec_prober.sv
// Self-checking bench for jt1943_sec_prober with a registered table ROM,
// a cen-clocked responder model and a table-level result model.
module tb_jt1943_sec_prober;

    localparam int N    = 32;
    localparam int AW   = 5;
    localparam int WAIT = 2;
    localparam int RUN_CLKS = N * (4 + WAIT) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_err, tbl_addr;
    logic [15:0]   tbl_data = 16'h0000;
    logic          tbl_ok = 1'b0;
    logic          sec_cs, sec_wr_n;
    logic [7:0]    sec_dout;
    logic [7:0]    sec_din = 8'h00;

    jt1943_sec_prober #(.N(N), .AW(AW), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err(first_err), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .tbl_ok(tbl_ok),
        .sec_cs(sec_cs), .sec_wr_n(sec_wr_n), .sec_dout(sec_dout), .sec_din(sec_din)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_ch [N];
    logic [7:0] rom_exp[N];
    logic [7:0] resp_map[256];
    int n_pass = 0;
    int n_total = 0;
    int cen_mode = 0;
    int ok_mode = 0;
    int cen_phase = 0;

    // cen: always high, or one clk in four
    always @(negedge clk) begin
        if (cen_mode == 0) begin
            cen = 1'b1;
        end else begin
            cen = (cen_phase == 0);
            cen_phase = (cen_phase + 1) % 4;
        end
    end

    // Registered table ROM; tbl_ok either stuck high or delayed after each address change
    logic [AW-1:0] last_addr = '0;
    int ok_cnt = 0;
    int ok_dly = 0;
    always @(posedge clk) begin
        tbl_data <= {rom_ch[tbl_addr], rom_exp[tbl_addr]};
        if (tbl_addr != last_addr) begin
            last_addr <= tbl_addr;
            ok_cnt    <= 0;
            ok_dly    <= $urandom_range(0, 7);
            tbl_ok    <= (ok_mode == 0);
        end else begin
            if (ok_cnt < 15) ok_cnt <= ok_cnt + 1;
            tbl_ok <= (ok_mode == 0) || (ok_cnt >= ok_dly);
        end
    end

    // Responder: write registered on a cen tick, answer registered one cen tick later
    logic [7:0] lat = 8'h00;
    always @(posedge clk) begin
        if (cen) begin
            if (sec_cs && !sec_wr_n) lat <= sec_dout;
            sec_din <= resp_map[lat];
        end
    end

    // Bus monitor
    logic pre_cs = 1'b0, pre_cen = 1'b0, pre_rst = 1'b1;
    logic [7:0] pulses[$];
    int viol = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        pre_cs  <= sec_cs;
        pre_cen <= cen;
        pre_rst <= rst;
    end
    always @(negedge clk) begin
        if (sec_cs && !pre_cs) pulses.push_back(sec_dout);
        if (!pre_rst) begin
            if (pre_cs && pre_cen && sec_cs) viol++;
            if (pre_cs && !pre_cen && !sec_cs) viol++;
        end
        if (sec_cs && (!busy || sec_wr_n)) viol++;
        if (done) done_cnt++;
    end

    function automatic int model_errs();
        int e = 0;
        for (int i = 0; i < N; i++) if (resp_map[rom_ch[i]] != rom_exp[i]) e++;
        return e;
    endfunction

    function automatic int model_first();
        for (int i = 0; i < N; i++) if (resp_map[rom_ch[i]] != rom_exp[i]) return i;
        return 0;
    endfunction

    function automatic int seq_bad();
        int b = 0;
        if (pulses.size() != N) return 1000 + pulses.size();
        for (int i = 0; i < N; i++) if (pulses[i] !== rom_ch[i]) b++;
        return b;
    endfunction

    logic [7:0] save_exp5, save_map9;

    task automatic init_table();
        for (int i = 0; i < 256; i++) resp_map[i] = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            rom_ch[i]  = 8'(i * 37 + 36);
            rom_exp[i] = 8'($urandom);
            resp_map[rom_ch[i]] = rom_exp[i];
        end
        save_exp5 = rom_exp[5];
        save_map9 = resp_map[rom_ch[9]];
    endtask

    task automatic corrupt_table();
        rom_exp[5] = save_exp5 ^ 8'h01;
        resp_map[rom_ch[9]] = save_map9 ^ 8'h5a;
    endtask

    task automatic restore_table();
        rom_exp[5] = save_exp5;
        resp_map[rom_ch[9]] = save_map9;
    endtask

    task automatic do_run(input int s1, input int s2, output int cyc, output bit tmo);
        bit f1 = 0, f2 = 0;
        pulses.delete();
        done_cnt = 0;
        viol = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        tmo = 1'b1;
        repeat (20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (!f1 && s1 >= 0 && pulses.size() == s1) begin start = 1'b1; f1 = 1; end
            if (!f2 && s2 >= 0 && pulses.size() == s2) begin start = 1'b1; f2 = 1; end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
        else n_pass++;
        n_total++;
        if ({err_cnt, first_err, tbl_addr} !== 16'h0000) $display("FAIL reset_counts: got %h want 0000", {err_cnt, first_err, tbl_addr});
        else n_pass++;
        n_total++;
        if ({sec_cs, sec_wr_n, sec_dout} !== 10'b0100000000) $display("FAIL reset_bus: got %b want 0100000000", {sec_cs, sec_wr_n, sec_dout});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_run();
        int cyc; bit tmo;
        cen_mode = 0; ok_mode = 0;
        do_run(-1, -1, cyc, tmo);
        n_total++;
        if (tmo || cyc != RUN_CLKS) $display("FAIL clean_latency: got %0d clk (timeout %0d) want %0d", cyc, tmo, RUN_CLKS);
        else n_pass++;
        n_total++;
        if (pass !== (model_errs() == 0) || err_cnt !== 6'(model_errs())) $display("FAIL clean_result: got pass %b err %0d want pass %0d err %0d", pass, err_cnt, model_errs() == 0, model_errs());
        else n_pass++;
        n_total++;
        if (seq_bad() != 0) $display("FAIL clean_strobes: got %0d bad strobes want 0", seq_bad());
        else n_pass++;
        n_total++;
        if (viol != 0 || done_cnt != 1 || busy !== 1'b0) $display("FAIL clean_protocol: got viol %0d done %0d busy %b want 0 1 0", viol, done_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_errors();
        int cyc; bit tmo;
        corrupt_table();
        cen_mode = 0; ok_mode = 0;
        do_run(-1, -1, cyc, tmo);
        n_total++;
        if (tmo || pass !== 1'b0) $display("FAIL err_pass: got pass %b timeout %0d want pass 0", pass, tmo);
        else n_pass++;
        n_total++;
        if (err_cnt !== 6'(model_errs())) $display("FAIL err_count: got %0d want %0d", err_cnt, model_errs());
        else n_pass++;
        n_total++;
        if (first_err !== 5'(model_first())) $display("FAIL err_first: got %0d want %0d", first_err, model_first());
        else n_pass++;
        n_total++;
        if (seq_bad() != 0 || viol != 0) $display("FAIL err_strobes: got bad %0d viol %0d want 0 0", seq_bad(), viol);
        else n_pass++;
    endtask

    task automatic test_slow_cen();
        int cyc; bit tmo;
        cen_mode = 1; ok_mode = 0;
        do_run(-1, -1, cyc, tmo);
        n_total++;
        if (tmo || err_cnt !== 6'(model_errs()) || first_err !== 5'(model_first()) || pass !== 1'b0)
            $display("FAIL slowcen_result: got err %0d first %0d pass %b want %0d %0d 0", err_cnt, first_err, pass, model_errs(), model_first());
        else n_pass++;
        n_total++;
        if (seq_bad() != 0 || viol != 0 || done_cnt != 1) $display("FAIL slowcen_strobes: got bad %0d viol %0d done %0d want 0 0 1", seq_bad(), viol, done_cnt);
        else n_pass++;
        restore_table();
        do_run(-1, -1, cyc, tmo);
        n_total++;
        if (tmo || pass !== 1'b1 || err_cnt !== 6'(model_errs()) || viol != 0) $display("FAIL slowcen_clean: got pass %b err %0d viol %0d want 1 %0d 0", pass, err_cnt, viol, model_errs());
        else n_pass++;
        cen_mode = 0;
    endtask

    task automatic test_tbl_ok_delay();
        int cyc; bit tmo;
        cen_mode = 0; ok_mode = 1;
        do_run(-1, -1, cyc, tmo);
        n_total++;
        if (tmo || pass !== 1'b1 || err_cnt !== 6'(model_errs())) $display("FAIL okdly_result: got pass %b err %0d want 1 %0d", pass, err_cnt, model_errs());
        else n_pass++;
        n_total++;
        if (seq_bad() != 0 || viol != 0) $display("FAIL okdly_strobes: got bad %0d viol %0d want 0 0", seq_bad(), viol);
        else n_pass++;
        n_total++;
        if (cyc <= RUN_CLKS) $display("FAIL okdly_latency: got %0d clk want more than %0d", cyc, RUN_CLKS);
        else n_pass++;
        ok_mode = 0;
    endtask

    task automatic test_reset_midrun();
        int cyc; bit tmo; bit hit = 0;
        corrupt_table();
        pulses.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (pulses.size() == 11 && !sec_cs) begin hit = 1; break; end
        end
        n_total++;
        if (!hit) $display("FAIL midrst_reach: got %0d strobes want 11", pulses.size());
        else n_pass++;
        done_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, sec_cs, pass} !== 3'b000 || err_cnt !== 6'd0 || tbl_addr !== 5'd0 || first_err !== 5'd0)
            $display("FAIL midrst_clear: got busy %b cs %b pass %b err %0d addr %0d first %0d want all 0", busy, sec_cs, pass, err_cnt, tbl_addr, first_err);
        else n_pass++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_total++;
        if (done_cnt != 0 || busy !== 1'b0) $display("FAIL midrst_quiet: got done %0d busy %b want 0 0", done_cnt, busy);
        else n_pass++;
        restore_table();
        do_run(-1, -1, cyc, tmo);
        n_total++;
        if (tmo || pass !== 1'b1 || err_cnt !== 6'd0 || seq_bad() != 0) $display("FAIL midrst_rerun: got pass %b err %0d bad %0d want 1 0 0", pass, err_cnt, seq_bad());
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int cyc; bit tmo;
        corrupt_table();
        do_run(4, 21, cyc, tmo);
        n_total++;
        if (tmo || done_cnt != 1 || cyc != RUN_CLKS) $display("FAIL restart_done: got done %0d clk %0d want 1 %0d", done_cnt, cyc, RUN_CLKS);
        else n_pass++;
        n_total++;
        if (err_cnt !== 6'(model_errs()) || first_err !== 5'(model_first())) $display("FAIL restart_err: got err %0d first %0d want %0d %0d", err_cnt, first_err, model_errs(), model_first());
        else n_pass++;
        n_total++;
        if (seq_bad() != 0 || viol != 0) $display("FAIL restart_strobes: got bad %0d viol %0d want 0 0", seq_bad(), viol);
        else n_pass++;
        restore_table();
    endtask

    initial begin
        init_table();
        test_reset();
        test_clean_run();
        test_errors();
        test_slow_cen();
        test_tbl_ok_delay();
        test_reset_midrun();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end

endmodule
